wshb_rr_arbiter: RTL and testbench
==================================

// Module: wshb_rr_arbiter
// PURPOSE
// - Shares one Wishbone slave port (SDRAM controller) between two Wishbone masters.
//   M0 is the VGA reader; M1 is the mire/pattern writer.
// - Round-robin arbitration with a registered grant. A burst limit stops either master starving the other.
// - Replaces the fixed-priority intercon between the video masters and the SDRAM controller.
// PARAMETERS
// - AW         32  Wishbone address width
// - DW         16  Wishbone data width; SW = DW/8 select bits
// - MAX_BURST  16  Acks a master may take while the other requests, before forced handover; must be >= 1
// PORTS
// - clk       in   1   system clock; all state on posedge
// - rst       in   1   asynchronous, active-high reset
// - m0_cyc, m0_stb, m0_we       in   1 each  VGA master cycle, strobe, write enable
// - m0_adr    in   AW  VGA master address
// - m0_dat_ms in   DW  VGA master write data
// - m0_sel    in   SW  VGA master byte selects
// - m0_ack    out  1   VGA master acknowledge
// - m1_*      same set as m0_*; mire master
// - s_cyc, s_stb, s_we  out  1 each  to SDRAM controller
// - s_adr     out  AW  to SDRAM controller
// - s_dat_ms  out  DW  to SDRAM controller
// - s_sel     out  SW  to SDRAM controller
// - s_cti     out  3   tied 3'b000 (classic cycles)
// - s_bte     out  2   tied 2'b00
// - s_ack     in   1   from SDRAM controller
// - s_dat_sm  in   DW  from SDRAM controller
// - dat_sm    out  DW  s_dat_sm broadcast to both masters
// - gnt       out  2   one-hot current grant; 2'b00 = idle
// BEHAVIOUR
// - FSM states: IDLE, GNT0, GNT1. Registers: state, last (last served), cnt (saturating ack counter).
// - Request: req0 = m0_cyc, req1 = m1_cyc.
// - Reset (async, immediate) sets state=IDLE, last=1, cnt=0. So M0 wins the first tie.
//   Outputs during reset: gnt=0, s_cyc=s_stb=s_we=0, s_adr=0, s_sel=0, m0_ack=m1_ack=0.
// - IDLE -> GNTx on the next clk when only reqx is set.
// - IDLE, both requesting: grant the master != last.
// - Arbitration latency is one cycle, from req sampled to gnt/s_cyc visible.
// - GNTx, reqx low: go to GNTy if reqy is set, else IDLE. No idle bubble on a clean handover.
// - GNTx forced handover: cnt == MAX_BURST-1 AND s_ack AND reqy -> GNTy next cycle.
//   Handover occurs only on an ack edge, so no transfer is cut mid-way.
//   The preempted master keeps cyc high and stalls (ack=0) until it is re-granted.
// - Slave stalled (s_ack=0) at the limit: hold the grant, no handover, until the ack arrives.
// - Leaving GNTx sets last=x and cnt=0.
// - cnt increments on s_ack while in GNTx, saturates at MAX_BURST-1, and is width $clog2(MAX_BURST).
// - cnt saturates and is not used when reqy is low, so a lone master streams indefinitely.
// - Datapath is combinational from the registered state.
//   - GNTx: s_cyc/stb/we/adr/sel/dat_ms = mx_*; mx_ack = s_ack; my_ack = 0.
//   - IDLE: all s_* = 0; both acks = 0.
// - s_ack seen while IDLE is ignored, never routed.
// - Both masters drop cyc in the same cycle as a forced handover: the next state is IDLE.
// - gnt = {state==GNT1, state==GNT0}. Never 2'b11.
// TESTING
// - Only M1 writes adr 0..3, s_ack high every cycle.
//   -> gnt=2'b10 one cycle after m1_cyc; 4 acks on m1_ack; m0_ack always 0; s_we=1.
// - M0 and M1 raise cyc in the same cycle after reset.
//   -> gnt=2'b01 first; M0 drops cyc after 3 acks -> gnt=2'b10 next cycle, no IDLE cycle.
// - MAX_BURST=4, both request continuously, s_ack always high.
//   -> grant alternates after exactly 4 acks each; the ack total equals the s_ack count; no ack to the ungranted master.
// - MAX_BURST=4, cnt=3, s_ack held low 5 cycles while M1 requests.
//   -> M0 keeps the grant; handover occurs the cycle after s_ack finally rises.
// - rst pulsed mid-burst, asynchronously between clk edges.
//   -> s_cyc, s_stb, acks and gnt are 0 immediately; after release, both requesting -> M0 granted first.
// - No requests for 20 cycles, with a spurious s_ack pulse.
//   -> state IDLE, s_cyc=0, m0_ack=m1_ack=0 throughout.

Source files
------------

// File: rtl/wshb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wshb_rr_arbiter
//
// Shares one Wishbone slave port (the SDRAM controller) between two Wishbone
// masters: M0 is the VGA reader and M1 is the mire/pattern writer.
// A master requests by raising cyc. Arbitration is round-robin with a
// registered grant. While the other master is waiting, a burst limit hands the
// port over after MAX_BURST acks. The handover happens only on an ack edge, so
// no transfer is cut short.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   m0_cyc/stb/we/adr/       VGA master request side
//     dat_ms/sel, m0_ack
//   m1_*                     same set for the mire master
//   s_cyc/stb/we/adr/        to SDRAM controller (routed from granted master)
//     dat_ms/sel
//   s_cti, s_bte             tied to classic cycles
//   s_ack, s_dat_sm          from SDRAM controller
//   dat_sm                   slave read data broadcast to both masters
//   gnt                      one-hot current grant, 2'b00 when idle
// -----------------------------------------------------------------------------
module wshb_rr_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 16,
   parameter int MAX_BURST = 16,
   localparam int SW       = DW / 8
) (
   input  logic          clk,
   input  logic          rst,
   // M0: VGA reader
   input  logic          m0_cyc,
   input  logic          m0_stb,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_adr,
   input  logic [DW-1:0] m0_dat_ms,
   input  logic [SW-1:0] m0_sel,
   output logic          m0_ack,
   // M1: mire writer
   input  logic          m1_cyc,
   input  logic          m1_stb,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_adr,
   input  logic [DW-1:0] m1_dat_ms,
   input  logic [SW-1:0] m1_sel,
   output logic          m1_ack,
   // Slave: SDRAM controller
   output logic          s_cyc,
   output logic          s_stb,
   output logic          s_we,
   output logic [AW-1:0] s_adr,
   output logic [DW-1:0] s_dat_ms,
   output logic [SW-1:0] s_sel,
   output logic [2:0]    s_cti,
   output logic [1:0]    s_bte,
   input  logic          s_ack,
   input  logic [DW-1:0] s_dat_sm,
   // Broadcast read data and grant status
   output logic [DW-1:0] dat_sm,
   output logic [1:0]    gnt
);

   // A one-ack limit still needs a one-bit counter.
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t        state;
   logic          last;   // master served most recently; the other wins a tie
   logic [CW-1:0] cnt;    // acks taken in the current grant, saturating

   logic req0, req1, at_limit;

   assign req0     = m0_cyc;
   assign req1     = m1_cyc;
   assign at_limit = (cnt == LIMIT);

   // NOTE: every register in this block uses non-blocking assignments so that
   // all of them update together on the edge, whatever their order in the code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 && req1)
                  state <= last ? GNT0 : GNT1;
               else if (req0)
                  state <= GNT0;
               else if (req1)
                  state <= GNT1;
            end
            GNT0: begin
               // Release on drop of cyc, or forced handover on the limiting ack.
               if (!req0 || (at_limit && s_ack && req1)) begin
                  state <= req1 ? GNT1 : IDLE;
                  last  <= 1'b0;
                  cnt   <= '0;
               end else if (s_ack && !at_limit) begin
                  cnt <= cnt + 1'b1;
               end
            end
            GNT1: begin
               if (!req1 || (at_limit && s_ack && req0)) begin
                  state <= req0 ? GNT0 : IDLE;
                  last  <= 1'b1;
                  cnt   <= '0;
               end else if (s_ack && !at_limit) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Datapath mux, combinational from the registered state.
   // NOTE: every output gets a default before the case, so no path leaves a
   // value held over and no latch is inferred.
   always_comb begin
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = 1'b0;
      s_adr    = '0;
      s_dat_ms = '0;
      s_sel    = '0;
      m0_ack   = 1'b0;
      m1_ack   = 1'b0;
      case (state)
         GNT0: begin
            s_cyc    = m0_cyc;
            s_stb    = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_ms = m0_dat_ms;
            s_sel    = m0_sel;
            m0_ack   = s_ack;
         end
         GNT1: begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_ms = m1_dat_ms;
            s_sel    = m1_sel;
            m1_ack   = s_ack;
         end
         default: ;  // IDLE: slave port quiet, a stray s_ack goes nowhere
      endcase
   end

   assign gnt    = {state == GNT1, state == GNT0};
   assign dat_sm = s_dat_sm;
   assign s_cti  = 3'b000;
   assign s_bte  = 2'b00;

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wshb_rr_arbiter
//
// Self-checking bench for wshb_rr_arbiter, built with MAX_BURST=4.
// Each row gives one cycle of stimulus (both cyc lines and s_ack) and the grant
// and acks expected in that cycle. A row is driven just after a rising edge,
// its expectation is queued, and the row is popped and compared on the
// following falling edge. The expected grant in a row reflects the arbitration
// decision taken on the previous row's inputs.
// -----------------------------------------------------------------------------
module tb_wshb_rr_arbiter;

   localparam int AW = 32;
   localparam int DW = 16;
   localparam int SW = DW / 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_cyc, m0_stb, m0_we, m0_ack;
   logic [AW-1:0] m0_adr;
   logic [DW-1:0] m0_dat_ms;
   logic [SW-1:0] m0_sel;
   logic          m1_cyc, m1_stb, m1_we, m1_ack;
   logic [AW-1:0] m1_adr;
   logic [DW-1:0] m1_dat_ms;
   logic [SW-1:0] m1_sel;
   logic          s_cyc, s_stb, s_we, s_ack;
   logic [AW-1:0] s_adr;
   logic [DW-1:0] s_dat_ms, s_dat_sm, dat_sm;
   logic [SW-1:0] s_sel;
   logic [2:0]    s_cti;
   logic [1:0]    s_bte;
   logic [1:0]    gnt;

   wshb_rr_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
      .s_ack(s_ack), .s_dat_sm(s_dat_sm),
      .dat_sm(dat_sm), .gnt(gnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       c0;
      logic       c1;
      logic       ack;
      logic [1:0] gnt;
      logic       a0;
      logic       a1;
   } vec_t;

   vec_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   m0_beats = 0;
   int   m1_beats = 0;
   int   obs_a0 = 0;
   int   obs_a1 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One cycle: drive a row, queue its expectation, compare on the falling edge.
   task automatic step(input vec_t v);
      vec_t          e;
      logic          exp_cyc;
      logic [AW-1:0] exp_adr;
      logic [DW-1:0] exp_dat;
      logic [SW-1:0] exp_sel;
      @(posedge clk);
      #1;
      m0_cyc    = v.c0;
      m0_stb    = v.c0;
      m1_cyc    = v.c1;
      m1_stb    = v.c1;
      s_ack     = v.ack;
      m0_adr    = 32'h0000_8000 + AW'(m0_beats);
      m1_adr    = AW'(m1_beats);
      m0_dat_ms = 16'hA000 + DW'(m0_beats);
      m1_dat_ms = 16'hB000 + DW'(m1_beats);
      s_dat_sm  = DW'($urandom);
      sb_q.push_back(v);
      @(negedge clk);
      e = sb_q.pop_front();
      exp_cyc = (e.gnt == 2'b01) ? e.c0 : (e.gnt == 2'b10) ? e.c1 : 1'b0;
      exp_adr = (e.gnt == 2'b01) ? m0_adr : (e.gnt == 2'b10) ? m1_adr : '0;
      exp_dat = (e.gnt == 2'b01) ? m0_dat_ms : (e.gnt == 2'b10) ? m1_dat_ms : '0;
      exp_sel = (e.gnt == 2'b01) ? m0_sel : (e.gnt == 2'b10) ? m1_sel : '0;
      check("gnt",      32'(gnt),      32'(e.gnt));
      check("m0_ack",   32'(m0_ack),   32'(e.a0));
      check("m1_ack",   32'(m1_ack),   32'(e.a1));
      check("s_cyc",    32'(s_cyc),    32'(exp_cyc));
      check("s_stb",    32'(s_stb),    32'(exp_cyc));
      check("s_we",     32'(s_we),     32'(e.gnt == 2'b10));
      check("s_adr",    s_adr,         exp_adr);
      check("s_dat_ms", 32'(s_dat_ms), 32'(exp_dat));
      check("s_sel",    32'(s_sel),    32'(exp_sel));
      check("dat_sm",   32'(dat_sm),   32'(s_dat_sm));
      obs_a0   += int'(m0_ack);
      obs_a1   += int'(m1_ack);
      m0_beats += int'(e.a0);
      m1_beats += int'(e.a1);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " gnt"},    32'(gnt),    32'd0);
      check({tag, " s_cyc"},  32'(s_cyc),  32'd0);
      check({tag, " s_stb"},  32'(s_stb),  32'd0);
      check({tag, " s_we"},   32'(s_we),   32'd0);
      check({tag, " s_adr"},  s_adr,       32'd0);
      check({tag, " s_sel"},  32'(s_sel),  32'd0);
      check({tag, " m0_ack"}, 32'(m0_ack), 32'd0);
      check({tag, " m1_ack"}, 32'(m1_ack), 32'd0);
   endtask

   task automatic clean_reset();
      @(posedge clk);
      #1;
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   // Watchdog: the bench is clock-driven, this only guards against a hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   vec_t seq_a[7];
   vec_t seq_b[8];
   vec_t seq_d[12];
   vec_t v;
   int   c_a0, c_a1;

   initial begin
      seq_a = '{
         '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1},
         '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1},
         '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1},
         '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1},
         '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0},
         '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}
      };
      seq_b = '{
         '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0},
         '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1},
         '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0},
         '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}
      };
      // M0 arrives at cnt=3 after its reset grant; the slave stalls 5 cycles.
      seq_d = '{
         '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1},
         '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0},
         '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}
      };

      // Reset held with both masters requesting and the slave acking.
      rst = 1'b1;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_sel = 2'b01;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 2'b11;
      m0_adr = 32'h1234; m1_adr = 32'h5678;
      m0_dat_ms = 16'h1111; m1_dat_ms = 16'h2222;
      s_ack = 1'b1; s_dat_sm = 16'h3333;
      #3;
      check_quiet("reset");
      check("s_cti", 32'(s_cti), 32'd0);
      check("s_bte", 32'(s_bte), 32'd0);
      #7;
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
      #2 rst = 1'b0;

      // Lone M1 writing adr 0..3.
      foreach (seq_a[i]) step(seq_a[i]);
      check("m1 beats", 32'(m1_beats), 32'd4);

      // Tie after reset: M0 first, clean handover to M1 without an idle cycle.
      clean_reset();
      foreach (seq_b[i]) step(seq_b[i]);

      // Continuous contention: grant alternates every MB acks.
      c_a0 = obs_a0;
      c_a1 = obs_a1;
      for (int i = 0; i <= 41; i++) begin
         v.c0  = (i <= 40);
         v.c1  = (i <= 40);
         v.ack = (i <= 40);
         if (i == 0)
            v.gnt = 2'b00;
         else
            v.gnt = (((i - 1) / MB) % 2 == 0) ? 2'b01 : 2'b10;
         v.a0 = v.ack && (v.gnt == 2'b01);
         v.a1 = v.ack && (v.gnt == 2'b10);
         step(v);
      end
      step('{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0});
      check("burst acks m0", 32'(obs_a0 - c_a0), 32'd20);
      check("burst acks m1", 32'(obs_a1 - c_a1), 32'd20);

      // M0 served last, so the tie goes to M1; reset lands mid-burst.
      step('{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0});
      step('{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1});
      @(posedge clk);
      #1;
      s_ack = 1'b1;
      #1 rst = 1'b1;
      #1 check_quiet("async reset");
      #1 rst = 1'b0;
      @(negedge clk);
      check("after reset gnt", 32'(gnt), 32'd0);
      // After release M0 wins, reaches the limit, then the slave stalls.
      foreach (seq_d[i]) step(seq_d[i]);

      // Idle with a spurious ack pulse.
      for (int i = 0; i < 20; i++) begin
         v = '{1'b0, 1'b0, (i == 7), 2'b00, 1'b0, 1'b0};
         step(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
